// File: rtl/iopage_ctl_if.sv
// CPU-side and device-side I/O page bus bundle for iopage_ctl.
// slave = controller view, master = CPU/device environment view.
interface iopage_ctl_if;
  logic        cpu_req;
  logic [12:0] cpu_addr;
  logic        cpu_wr;
  logic        cpu_byte_op;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out;
  logic        cpu_ack;
  logic        cpu_berr;
  logic [12:0] iopage_addr;
  logic [15:0] iopage_wdata;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic [3:0]  dev_decode;
  logic [3:0]  dev_ready;
  logic [63:0] dev_data;
  logic        decode_conflict;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wr, cpu_byte_op, cpu_data_in,
    input  dev_decode, dev_ready, dev_data,
    output cpu_data_out, cpu_ack, cpu_berr,
    output iopage_addr, iopage_wdata, iopage_rd, iopage_wr, iopage_byte_op,
    output decode_conflict
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wr, cpu_byte_op, cpu_data_in,
    output dev_decode, dev_ready, dev_data,
    input  cpu_data_out, cpu_ack, cpu_berr,
    input  iopage_addr, iopage_wdata, iopage_rd, iopage_wr, iopage_byte_op,
    input  decode_conflict
  );
endinterface

// File: rtl/iopage_ctl.sv
// I/O page access controller: latches a CPU request, strobes the decoded
// device slot, waits up to TIMEOUT cycles for ready, then acks or bus-errors.
//
// state  | meaning
// IDLE   | waiting for cpu_req
// STROBE | strobes up, slot decoded, ready sampled
// WAIT   | strobes up, counting cycles until ready or timeout
// ACK    | one-cycle completion pulse
// BERR   | one-cycle bus-error pulse
module iopage_ctl #(
  parameter int unsigned TIMEOUT = 8
) (
  input logic        clk,
  input logic        reset,
  iopage_ctl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STROBE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_BERR   = 3'd4;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic [12:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        conflict_q, conflict_d;

  logic [1:0]  dec_sel;
  logic        dec_multi;
  logic [1:0]  slot;
  logic        slot_ready;
  logic [15:0] slot_data;
  logic [3:0]  cnt_inc;

  always_comb begin
    dec_sel = 2'd0;
    if (bus.dev_decode[0])      dec_sel = 2'd0;
    else if (bus.dev_decode[1]) dec_sel = 2'd1;
    else if (bus.dev_decode[2]) dec_sel = 2'd2;
    else if (bus.dev_decode[3]) dec_sel = 2'd3;
  end

  assign dec_multi  = (bus.dev_decode & (bus.dev_decode - 4'd1)) != 4'd0;
  // STROBE uses the live decode; WAIT uses the slot registered in STROBE.
  assign slot       = (state_q == S_STROBE) ? dec_sel : sel_q;
  assign slot_ready = bus.dev_ready[slot];
  assign slot_data  = bus.dev_data[{slot, 4'b0000} +: 16];
  assign cnt_inc    = cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    wr_d       = wr_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    conflict_d = conflict_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          wr_d    = bus.cpu_wr;
          byte_d  = bus.cpu_byte_op;
          wdata_d = bus.cpu_data_in;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (bus.dev_decode == 4'd0) begin
          state_d = S_BERR;
        end else begin
          sel_d      = dec_sel;
          conflict_d = conflict_q | dec_multi;
          if (slot_ready) begin
            state_d = S_ACK;
            if (!wr_q) rdata_d = slot_data;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      S_WAIT: begin
        // Ready is checked before the timeout so a late ready still wins.
        if (slot_ready) begin
          state_d = S_ACK;
          if (!wr_q) rdata_d = slot_data;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) state_d = S_BERR;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_BERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      sel_q      <= 2'd0;
      wr_q       <= 1'b0;
      byte_q     <= 1'b0;
      addr_q     <= 13'd0;
      wdata_q    <= 16'd0;
      rdata_q    <= 16'd0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      conflict_q <= conflict_d;
    end
  end

  // All outputs come straight from registers, so reset clears them at once.
  assign bus.cpu_data_out    = rdata_q;
  assign bus.cpu_ack         = (state_q == S_ACK);
  assign bus.cpu_berr        = (state_q == S_BERR);
  assign bus.iopage_addr     = addr_q;
  assign bus.iopage_wdata    = wdata_q;
  assign bus.iopage_byte_op  = byte_q;
  assign bus.iopage_rd       = ((state_q == S_STROBE) || (state_q == S_WAIT)) && !wr_q;
  assign bus.iopage_wr       = ((state_q == S_STROBE) || (state_q == S_WAIT)) && wr_q;
  assign bus.decode_conflict = conflict_q;

endmodule

// File: tb/tb_iopage_ctl.sv
// Bench for iopage_ctl: directed cases plus random accesses against a
// transaction-level model of strobe length, outcome, read data and conflict.
module tb_iopage_ctl;
  localparam int T = 8;
  localparam int NEVER = 99;

  logic clk;
  logic reset;
  iopage_ctl_if bus();

  iopage_ctl #(.TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit in_done = 0;
  logic [15:0] m_data = 16'd0;
  bit m_conf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] dec);
    for (int i = 0; i < 4; i++) if (dec[i]) return i;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd"}, bus.iopage_rd, 0);
    chk({tag, "_wr"}, bus.iopage_wr, 0);
    chk({tag, "_ack"}, bus.cpu_ack, 0);
    chk({tag, "_berr"}, bus.cpu_berr, 0);
    chk({tag, "_data"}, bus.cpu_data_out, 0);
    chk({tag, "_addr"}, bus.iopage_addr, 0);
    chk({tag, "_wdata"}, bus.iopage_wdata, 0);
    chk({tag, "_bop"}, bus.iopage_byte_op, 0);
    chk({tag, "_conf"}, bus.decode_conflict, 0);
  endtask

  // Starts at a negedge; returns at the negedge of the ack/berr cycle.
  task automatic access(input string tag, input logic wr, input logic bop,
                        input logic [12:0] addr, input logic [15:0] wdata,
                        input logic [3:0] dec, input int rdy_at,
                        input bit use_force, input logic [15:0] force_data);
    int len, sel;
    bit ok, multi;
    logic [15:0] rdata, exp_data;
    logic [3:0] rdy;
    sel   = lowest(dec);
    multi = $countones(dec) > 1;
    rdata = m_data;
    if (dec == 4'd0)      begin len = 1;          ok = 0; end
    else if (rdy_at <= T) begin len = 1 + rdy_at; ok = 1; end
    else                  begin len = 1 + T;      ok = 0; end

    bus.cpu_req = 1'b1; bus.cpu_wr = wr; bus.cpu_byte_op = bop;
    bus.cpu_addr = addr; bus.cpu_data_in = wdata;
    bus.dev_decode = dec;
    bus.dev_ready = 4'($urandom);
    bus.dev_data = {$urandom, $urandom};
    if (in_done) @(posedge clk);
    @(posedge clk);
    for (int n = 1; n <= len + 1; n++) begin
      @(negedge clk);
      bus.dev_data = {$urandom, $urandom};
      if (n <= len) begin
        bus.cpu_req = 1'($urandom); bus.cpu_wr = 1'($urandom);
        bus.cpu_byte_op = 1'($urandom); bus.cpu_addr = 13'($urandom);
        bus.cpu_data_in = 16'($urandom);
        rdy = 4'($urandom);
        if (dec != 4'd0) begin
          rdy[sel] = ok && (n == len);
          if (ok && n == len) begin
            if (use_force) bus.dev_data[sel*16 +: 16] = force_data;
            rdata = bus.dev_data[sel*16 +: 16];
          end
        end
        bus.dev_ready = rdy;
      end else begin
        bus.cpu_req = 1'b0;
        bus.dev_decode = 4'($urandom);
        bus.dev_ready = 4'($urandom);
      end
      exp_data = (n == len + 1 && ok && !wr) ? rdata : m_data;
      chk({tag, "_rd"}, bus.iopage_rd, (n <= len) && !wr);
      chk({tag, "_wr"}, bus.iopage_wr, (n <= len) && wr);
      chk({tag, "_ack"}, bus.cpu_ack, (n == len + 1) && ok);
      chk({tag, "_berr"}, bus.cpu_berr, (n == len + 1) && !ok);
      chk({tag, "_addr"}, bus.iopage_addr, addr);
      chk({tag, "_wdata"}, bus.iopage_wdata, wdata);
      chk({tag, "_bop"}, bus.iopage_byte_op, bop);
      chk({tag, "_data"}, bus.cpu_data_out, exp_data);
      chk({tag, "_conf"}, bus.decode_conflict, m_conf || (n >= 2 && multi));
    end
    if (ok && !wr) m_data = rdata;
    if (multi) m_conf = 1;
    in_done = 1;
  endtask

  initial begin
    logic [3:0] dec;
    int ra;
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_byte_op = 0;
    bus.cpu_addr = 0; bus.cpu_data_in = 0;
    bus.dev_decode = 0; bus.dev_ready = 0; bus.dev_data = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    in_done = 0;

    access("rom_read", 0, 0, 13'o13000, 16'h1234, 4'b0001, 0, 1, 16'o000240);
    chk("rom_read_value", bus.cpu_data_out, 16'o000240);
    access("wait3_read", 0, 1, 13'o17560, 16'h0, 4'b0010, 3, 1, 16'o177564);
    chk("wait3_read_value", bus.cpu_data_out, 16'o177564);
    access("nodec_read", 0, 0, 13'o00100, 16'h0, 4'b0000, 0, 0, 16'h0);
    access("timeout_wr", 1, 0, 13'o04000, 16'hbeef, 4'b0100, NEVER, 0, 16'h0);
    access("ready_at_t", 0, 0, 13'o00200, 16'h0, 4'b1000, T, 0, 16'h0);
    access("ready_t_m1", 1, 1, 13'o00300, 16'h55aa, 4'b1000, T - 1, 0, 16'h0);
    access("conflict", 0, 0, 13'o00400, 16'h0, 4'b0011, 0, 1, 16'h5a5a);
    chk("conflict_value", bus.cpu_data_out, 16'h5a5a);
    access("conflict_hold", 1, 0, 13'o00500, 16'h1111, 4'b0100, 1, 0, 16'h0);

    // Reset during the second WAIT cycle of a read.
    bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 13'o00600;
    bus.dev_decode = 4'b0010; bus.dev_ready = 4'b0000;
    if (in_done) @(posedge clk);
    @(posedge clk);
    @(negedge clk); bus.cpu_req = 0;
    chk("rst_mid_strobe_rd", bus.iopage_rd, 1);
    @(negedge clk);
    chk("rst_mid_wait1_rd", bus.iopage_rd, 1);
    @(negedge clk);
    chk("rst_mid_wait2_rd", bus.iopage_rd, 1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    reset = 1'b0;
    m_data = 16'd0; m_conf = 0; in_done = 0;
    access("after_rst", 0, 0, 13'o00700, 16'h0, 4'b0010, 2, 0, 16'h0);

    for (int i = 0; i < 80; i++) begin
      dec = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      ra  = $urandom_range(0, T + 2);
      if (ra > T) ra = NEVER;
      access("rand", 1'($urandom), 1'($urandom), 13'($urandom), 16'($urandom),
             dec, ra, 0, 16'h0);
    end

    bus.cpu_req = 0;
    repeat (3) @(negedge clk);
    chk("idle_ack", bus.cpu_ack, 0);
    chk("idle_berr", bus.cpu_berr, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
